// File: rtl/sram_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding and default widths.
// Imported by sram_arbiter; no ports.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int N_REQ_DEF   = 2;
  localparam int ADDR_W_DEF  = 24;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or after ptr, circular.
// Ports: req (N), ptr (IW) in; gnt one-hot (N), idx (IW), any out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N, so one subtraction is enough to wrap
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between N_REQ requesters, one op at a time.
// Ports: req_* in/ready out, rsp_* out, sram_* to/from controller, busy.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    sram_wr_en,
  output logic                    sram_rd_en,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [DATA_W-1:0]       sram_wdata,
  input  logic [DATA_W-1:0]       sram_rdata,
  input  logic                    sram_completed,
  output logic                    busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] O_LAST = IW'(N_REQ - 1);

  state_t state;
  state_t state_nxt;

  logic [N_REQ-1:0]  gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;

  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic [N_REQ-1:0]  owner_oh;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [TW-1:0]     timer;
  logic              expire;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign expire = (timer == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A completion in ISSUE is handled exactly like one in WAIT.
  // A completion on the expiry cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (gnt_any) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = sram_completed ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (sram_completed || expire) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      owner    <= '0;
      owner_oh <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      timer    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            owner    <= gnt_idx;
            owner_oh <= gnt;
            we_q     <= req_we[gnt_idx];
            addr_q   <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            wdata_q  <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            err_q    <= 1'b0;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          if (sram_completed)
            rdata_q <= we_q ? '0 : sram_rdata;
        end
        ST_WAIT: begin
          if (sram_completed) begin
            rdata_q <= we_q ? '0 : sram_rdata;
          end else if (expire) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr <= (owner == O_LAST) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign req_ready  = (state == ST_ISSUE) ? owner_oh : '0;
  assign rsp_valid  = (state == ST_RESP) ? owner_oh : '0;
  assign rsp_err    = (state == ST_RESP) & err_q;
  assign rsp_rdata  = rdata_q;
  assign sram_wr_en = (state == ST_ISSUE) & we_q;
  assign sram_rd_en = (state == ST_ISSUE) & ~we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 20-cycle SRAM controller model.
// Two requesters, TIMEOUT=32, 128 KiB stub memory.
module tb_sram_arbiter;

  localparam int K = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we = '0;
  logic [47:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        sram_wr_en;
  logic        sram_rd_en;
  logic [23:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata = '0;
  logic        sram_completed = 1'b0;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  sram_arbiter #(
    .N_REQ   (2),
    .ADDR_W  (24),
    .DATA_W  (8),
    .TIMEOUT (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .sram_wr_en     (sram_wr_en),
    .sram_rd_en     (sram_rd_en),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata),
    .sram_completed (sram_completed),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // controller model: completed K cycles after the enable
  logic [7:0]  mem [0:131071];
  logic [16:0] maddr = '0;
  int          mcnt = 0;
  bit          suppress = 1'b0;

  always @(posedge clk) begin
    if (sram_wr_en || sram_rd_en) begin
      if (sram_wr_en) mem[sram_addr[16:0]] <= sram_wdata;
      maddr <= sram_addr[16:0];
      if (!suppress) mcnt <= K - 1;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
    sram_completed <= (mcnt == 1);
    if (mcnt == 1) sram_rdata <= mem[maddr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // protocol monitor
  logic [23:0] a_ref = '0;
  always @(negedge clk) begin
    if (rst_n && busy) begin
      chk("wr_rd_excl", 32'(sram_wr_en & sram_rd_en), 0);
      chk("rdy_onehot", 32'($onehot0(req_ready)), 1);
      chk("rsp_onehot", 32'($onehot0(rsp_valid)), 1);
      if (sram_wr_en || sram_rd_en) a_ref = sram_addr;
      else chk("addr_stable", 32'(sram_addr), 32'(a_ref));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy, req_ready, rsp_valid, rsp_err,
                            sram_wr_en, sram_rd_en}), 0);
    chk({tag, "_addr"}, 32'(sram_addr), 0);
    chk({tag, "_wdata"}, 32'(sram_wdata), 0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 0);
  endtask

  task automatic xact(input string tag, input int i, input bit we,
                      input logic [23:0] a, input logic [7:0] d,
                      input int lat, input bit err,
                      input logic [7:0] rd);
    int t0, ti, n;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*24 +: 24] = a;
    req_wdata[i*8 +: 8] = d;
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!req_ready[i] && n < 64);
    req_valid[i] = 1'b0;
    chk({tag, "_ready"}, 32'(req_ready[i]), 1);
    chk({tag, "_acc_lat"}, cyc - t0, 1);
    chk({tag, "_wr_en"}, 32'(sram_wr_en), 32'(we));
    chk({tag, "_rd_en"}, 32'(sram_rd_en), 32'(!we));
    chk({tag, "_addr"}, 32'(sram_addr), 32'(a));
    if (we) chk({tag, "_wdata"}, 32'(sram_wdata), 32'(d));
    ti = cyc;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!rsp_valid[i] && n < 100);
    chk({tag, "_rsp"}, 32'(rsp_valid[i]), 1);
    chk({tag, "_rsp_lat"}, cyc - ti, lat);
    chk({tag, "_err"}, 32'(rsp_err), 32'(err));
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(rd));
  endtask

  initial begin
    int n, n_rsp;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // single write then readback from the other requester
    xact("wr10", 0, 1'b1, 24'h000010, 8'hA5, 21, 1'b0, 8'h00);
    xact("rd10", 1, 1'b0, 24'h000010, 8'h00, 21, 1'b0, 8'hA5);

    // contention: both held valid, grants must alternate 0,1,0,1
    @(negedge clk);
    req_we = 2'b00;
    req_addr = {24'h000010, 24'h000010};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end
      while (req_ready == 2'b00 && n < 64);
      chk("rr_grant", 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
    end
    req_valid = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end
    while (busy && n < 64);
    chk("rr_drain", 32'(busy), 0);

    // lost completion -> timeout, then normal service
    suppress = 1'b1;
    xact("tmo", 0, 1'b0, 24'h000010, 8'h00, 33, 1'b1, 8'h00);
    suppress = 1'b0;
    xact("post_tmo", 1, 1'b0, 24'h000010, 8'h00, 21, 1'b0, 8'hA5);

    // reset in the middle of WAIT
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[23:0] = 24'h000020;
    req_wdata[7:0] = 8'h77;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!req_ready[0] && n < 64);
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    repeat (3) @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || busy) n_rsp++;
    end
    chk("stray_ignored", n_rsp, 0);

    xact("w1ffff", 0, 1'b1, 24'h01FFFF, 8'h3C, 21, 1'b0, 8'h00);
    xact("r1ffff", 1, 1'b0, 24'h01FFFF, 8'h00, 21, 1'b0, 8'h3C);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
